// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM constants, fade FSM state encoding and breathing defaults
package pwm_pkg;
   localparam int PWM_N        = 32;
   localparam int CLK_FREQ_MHZ = 27;
   localparam logic [PWM_N-1:0] BREATH_PERIOD = 32'd31815;
   localparam logic [PWM_N-1:0] BREATH_MIN    = 32'h6fffffff;
   localparam logic [PWM_N-1:0] BREATH_MAX    = 32'hffffffff;
   localparam logic [PWM_N-1:0] BREATH_STEP   = 32'd100000;
   typedef enum logic [1:0] {IDLE, RAMP, GAP} fade_state_t;
endpackage

// File: rtl/fade_gap_timer.sv
// fade_gap_timer: loadable down-counter; expired asserts in the last enabled cycle (at least one cycle)
module fade_gap_timer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);
   logic [W-1:0] cnt;
   // reload on demand, otherwise count down while enabled and stop at zero
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && cnt != '0) cnt <= cnt - W'(1);
   end
   assign expired = en && (cnt <= W'(1));
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: command-driven duty fader for the pwm generator; PWM_FADE_PREEMPT_EN lets new commands abort a fade
module pwm_fade_ctrl
   import pwm_pkg::*;
#(
   parameter int N            = pwm_pkg::PWM_N,
   parameter int CLK_FREQ_MHZ = pwm_pkg::CLK_FREQ_MHZ,
   parameter int GAP_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [N-1:0]     cmd_period,
   input  logic [N-1:0]     cmd_target,
   input  logic [N-1:0]     cmd_step,
   input  logic [GAP_W-1:0] cmd_gap_us,
   output logic [N-1:0]     period,
   output logic [N-1:0]     duty,
   output logic             busy,
   output logic             done
);
   fade_state_t state, state_n;
   logic [N-1:0] target, step, duty_n;
   logic [31:0]  gap_cyc;
   logic         accept, expired, done_n;

`ifdef PWM_FADE_PREEMPT_EN
   assign cmd_ready = 1'b1;
`else
   assign cmd_ready = (state == IDLE);
`endif
   assign accept = cmd_valid && cmd_ready;
   assign busy   = (state != IDLE);

   // one step toward the target; comparing the remaining distance against the step avoids any wrap
   always_comb begin
      duty_n = (step == '0 || duty == target) ? target :
               (duty < target) ? ((target - duty <= step) ? target : duty + step) :
                                 ((duty - target <= step) ? target : duty - step);
   end

   // next state and done; an accepted command always restarts at RAMP and suppresses done
   always_comb begin
      state_n = accept ? RAMP :
                (state == RAMP) ? ((duty_n == target) ? IDLE : GAP) :
                (state == GAP && expired) ? RAMP : state;
      done_n  = (state == RAMP) && !accept && (duty_n == target);
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end

   // command latch, duty update and registered done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         period  <= '0;
         duty    <= '0;
         target  <= '0;
         step    <= '0;
         gap_cyc <= '0;
         done    <= 1'b0;
      end else begin
         done <= done_n;
         if (accept) begin
            period  <= cmd_period;
            target  <= cmd_target;
            step    <= cmd_step;
            gap_cyc <= 32'(cmd_gap_us) * 32'(CLK_FREQ_MHZ);
         end else if (state == RAMP) begin
            duty <= duty_n;
         end
      end
   end

   fade_gap_timer #(.W(32)) u_gap (
      .clk      (clk),
      .rst      (rst),
      .load     (state == RAMP),
      .load_val (gap_cyc),
      .en       (state == GAP),
      .expired  (expired)
   );
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed self-checking bench for pwm_fade_ctrl (PWM_FADE_PREEMPT_EN section runs only when defined)
module tb_pwm_fade_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_period = '0, cmd_target = '0, cmd_step = '0;
   logic [15:0] cmd_gap_us = '0;
   logic [31:0] period, duty;
   logic        busy, done;
   int          n_chk = 0, n_pass = 0;

   pwm_fade_ctrl #(.N(32), .CLK_FREQ_MHZ(27), .GAP_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_period (cmd_period),
      .cmd_target (cmd_target),
      .cmd_step   (cmd_step),
      .cmd_gap_us (cmd_gap_us),
      .period     (period),
      .duty       (duty),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] p, input logic [31:0] t, input logic [31:0] s, input logic [15:0] g);
      cmd_period = p;
      cmd_target = t;
      cmd_step   = s;
      cmd_gap_us = g;
      cmd_valid  = 1'b1;
      tick();
      cmd_valid  = 1'b0;
   endtask

   initial begin
      int n;
      logic [31:0] prev;
      tick();
      tick();
      check("rst_period", period, 0);
      check("rst_duty", duty, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", cmd_ready, 1);
      rst = 1'b0;
      tick();

      send(32'd31815, 32'h300, 32'h100, 16'd0);
      check("up_period", period, 32'd31815);
      check("up_busy", busy, 1);
      check("up_ready_low", cmd_ready, 0);
      check("up_duty_t0", duty, 32'h0);
      tick();
      check("up_duty_1", duty, 32'h100);
      tick();
      check("up_duty_hold", duty, 32'h100);
      tick();
      check("up_duty_2", duty, 32'h200);
      check("up_no_done", done, 0);
      tick();
      tick();
      check("up_duty_3", duty, 32'h300);
      check("up_done", done, 1);
      check("up_busy_fall", busy, 0);
      check("up_ready_rise", cmd_ready, 1);
      tick();
      check("up_done_once", done, 0);

      send(32'd31815, 32'h50, 32'h100, 16'd0);
      tick();
      check("dn_duty_1", duty, 32'h200);
      tick();
      tick();
      check("dn_duty_2", duty, 32'h100);
      check("dn_no_done", done, 0);
      tick();
      tick();
      check("dn_clamp", duty, 32'h50);
      check("dn_done", done, 1);
      tick();
      check("dn_done_once", done, 0);

      send(32'd31815, 32'hFFFF_FF00, 32'h0, 16'd5);
      tick();
      check("jump_duty", duty, 32'hFFFF_FF00);
      check("jump_done", done, 1);
      send(32'd31815, 32'hFFFF_FFFF, 32'h1000, 16'd0);
      tick();
      check("sat_duty", duty, 32'hFFFF_FFFF);
      check("sat_done", done, 1);

      send(32'd31815, 32'hFFFF_FFDF, 32'h10, 16'd2);
      tick();
      check("gap_first", duty, 32'hFFFF_FFEF);
      prev = duty;
      n = 0;
      while (duty == prev && n < 200) begin
         tick();
         n++;
      end
      check("gap_cadence", n, 55);
      check("gap_final", duty, 32'hFFFF_FFDF);
      check("gap_done", done, 1);

      cmd_period = 32'd777;
      cmd_target = 32'h0;
      cmd_step   = 32'h8000_0000;
      cmd_gap_us = 16'd0;
      cmd_valid  = 1'b1;
      tick();
      check("hs_ready_busy", cmd_ready, 0);
      tick();
      check("hs_duty_1", duty, 32'h7FFF_FFDF);
      check("hs_ready_ramp", cmd_ready, 0);
      tick();
      check("hs_ready_gap", cmd_ready, 0);
      tick();
      check("hs_duty_0", duty, 32'h0);
      check("hs_done", done, 1);
      tick();
      check("hs_reaccept_busy", busy, 1);
      cmd_valid = 1'b0;
      tick();
      check("hs_same_duty_done", done, 1);
      check("hs_same_duty", duty, 32'h0);

      send(32'd1234, 32'h1000, 32'h100, 16'd2);
      tick();
      check("rst_mid_duty_1", duty, 32'h100);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_duty", duty, 0);
      check("rstmid_period", period, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_ready", cmd_ready, 1);
      for (int i = 0; i < 60; i++) tick();
      check("rstmid_no_resume", duty, 0);
      check("rstmid_still_idle", busy, 0);

`ifdef PWM_FADE_PREEMPT_EN
      send(32'd31815, 32'h1000, 32'h100, 16'd1);
      tick();
      check("pre_duty_1", duty, 32'h100);
      tick();
      tick();
      check("pre_ready_gap", cmd_ready, 1);
      send(32'd31815, 32'h0, 32'h40, 16'd0);
      check("pre_abort_busy", busy, 1);
      check("pre_abort_nodone", done, 0);
      check("pre_keep_duty", duty, 32'h100);
      tick();
      check("pre_duty_a", duty, 32'hC0);
      tick();
      tick();
      check("pre_duty_b", duty, 32'h80);
      tick();
      tick();
      check("pre_duty_c", duty, 32'h40);
      check("pre_no_done", done, 0);
      tick();
      tick();
      check("pre_duty_d", duty, 32'h0);
      check("pre_done", done, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
